// File: rtl/mmio_timer_serial_unit_if.sv
// Request/response, serial sink and interrupt signals of the MMIO timer/serial target.
// The master side is the load/store path; the slave side is the unit itself.
interface mmio_timer_serial_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqIsStore;
  logic [21:0] reqAddr;
  logic [31:0] reqWriteData;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspError;
  logic        serialValid;
  logic [7:0]  serialData;
  logic        serialReady;
  logic        timerIrq;

  modport master (
    output reqValid, reqIsStore, reqAddr, reqWriteData, serialReady,
    input  reqReady, rspValid, rspData, rspError, serialValid, serialData, timerIrq
  );

  modport slave (
    input  reqValid, reqIsStore, reqAddr, reqWriteData, serialReady,
    output reqReady, rspValid, rspData, rspError, serialValid, serialData, timerIrq
  );
endinterface

// File: rtl/mmio_timer_serial_unit.sv
// MMIO target: 64-bit mtime/mtimecmp with compare interrupt, plus a serial byte FIFO
// drained by a ready/valid sink. Responses are registered, one cycle after acceptance.
module mmio_timer_serial_unit #(
  parameter int SERIAL_FIFO_DEPTH = 4,
  parameter int TIMER_PRESCALE    = 1
) (
  input logic                clk,
  input logic                rst,
  mmio_timer_serial_unit_if.slave bus
);
  localparam int PW  = (SERIAL_FIFO_DEPTH > 1) ? $clog2(SERIAL_FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int PSW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_MTIME_LO, SEL_MTIME_HI, SEL_CMP_LO, SEL_CMP_HI, SEL_SERIAL
  } sel_e;

  sel_e        sel;
  logic        full, accept, wr, tick, push, pop, err;
  logic [31:0] rdata;

  logic [63:0]  mtime_q, mtime_d, cmp_q, cmp_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic         irq_q;
  logic [7:0]   mem_q [SERIAL_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         rsp_valid_q, rsp_err_q;
  logic [31:0]  rsp_data_q;

  // The uncachable attribute is irrelevant to this target.
  logic unused_uncachable;
  assign unused_uncachable = bus.reqAddr[21];

  always_comb begin
    sel = SEL_NONE;
    if (bus.reqAddr[20]) begin
      case (bus.reqAddr[19:0])
        20'h00000: sel = SEL_MTIME_LO;
        20'h00004: sel = SEL_MTIME_HI;
        20'h00008: sel = SEL_CMP_LO;
        20'h0000C: sel = SEL_CMP_HI;
        20'h02000: sel = SEL_SERIAL;
        default:   sel = SEL_NONE;
      endcase
    end
  end

  assign full   = (cnt_q == CW'(SERIAL_FIFO_DEPTH));
  // Full FIFO blocks serial stores even when a pop happens in the same cycle.
  assign bus.reqReady = !(bus.reqValid && bus.reqIsStore && (sel == SEL_SERIAL) && full);
  assign accept = bus.reqValid && bus.reqReady;
  assign wr     = accept && bus.reqIsStore;
  assign err    = (sel == SEL_NONE);
  assign tick   = (presc_q == PSW'(TIMER_PRESCALE - 1));
  assign push   = wr && (sel == SEL_SERIAL);
  assign pop    = (cnt_q != '0) && bus.serialReady;

  always_comb begin
    presc_d = tick ? '0 : presc_q + PSW'(1);

    mtime_d = mtime_q;
    if (wr && sel == SEL_MTIME_LO)      mtime_d[31:0]  = bus.reqWriteData;
    else if (wr && sel == SEL_MTIME_HI) mtime_d[63:32] = bus.reqWriteData;
    else if (tick)                      mtime_d        = mtime_q + 64'd1;

    cmp_d = cmp_q;
    if (wr && sel == SEL_CMP_LO) cmp_d[31:0]  = bus.reqWriteData;
    if (wr && sel == SEL_CMP_HI) cmp_d[63:32] = bus.reqWriteData;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (!bus.reqIsStore) begin
      case (sel)
        SEL_MTIME_LO: rdata = mtime_q[31:0];
        SEL_MTIME_HI: rdata = mtime_q[63:32];
        SEL_CMP_LO:   rdata = cmp_q[31:0];
        SEL_CMP_HI:   rdata = cmp_q[63:32];
        SEL_SERIAL:   rdata = 32'(cnt_q);
        default:      rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= '0;
      cmp_q       <= '1;
      presc_q     <= '0;
      irq_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      for (int i = 0; i < SERIAL_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      presc_q     <= presc_d;
      irq_q       <= (mtime_q >= cmp_q);
      cnt_q       <= cnt_d;
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && err;
      rsp_data_q  <= (accept && !err) ? rdata : '0;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.reqWriteData[7:0];
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign bus.rspValid    = rsp_valid_q;
  assign bus.rspData     = rsp_data_q;
  assign bus.rspError    = rsp_err_q;
  assign bus.serialValid = (cnt_q != '0);
  assign bus.serialData  = mem_q[rd_ptr_q];
  assign bus.timerIrq    = irq_q;
endmodule

// File: tb/tb_mmio_timer_serial_unit.sv
// Bench for mmio_timer_serial_unit: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model built from 64-bit arithmetic and a byte queue.
module tb_mmio_timer_serial_unit;
  localparam int DEPTH = 4;
  localparam int PRE   = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_timer_serial_unit_if bus();

  mmio_timer_serial_unit #(.SERIAL_FIFO_DEPTH(DEPTH), .TIMER_PRESCALE(PRE)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  bit [63:0]   m_time, m_cmp;
  int          m_pre;
  bit          m_irq, m_rv, m_re, m_rst;
  bit [31:0]   m_rd;
  byte unsigned m_q[$];

  // Observations taken before the edge of the most recent step
  bit          obs_rdy;
  byte unsigned popped[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [21:0] a);
    if (!a[20]) return -1;
    case (a[19:0])
      20'h00000: return 0;
      20'h00004: return 1;
      20'h00008: return 2;
      20'h0000C: return 3;
      20'h02000: return 4;
      default:   return -1;
    endcase
  endfunction

  task automatic step(input bit r, input bit v, input bit s, input logic [21:0] a,
                      input logic [31:0] d, input bit sr);
    int k;
    bit rdy, acc;
    rst = r; bus.reqValid = v; bus.reqIsStore = s; bus.reqAddr = a;
    bus.reqWriteData = d; bus.serialReady = sr;
    #1;
    k   = dec(a);
    rdy = !(v && s && k == 4 && m_q.size() == DEPTH);
    obs_rdy = bus.reqReady;
    chk("reqReady", bus.reqReady, rdy);
    if (bus.serialValid && sr && !r) popped.push_back(bus.serialData);
    @(posedge clk);
    if (r) begin
      m_time = '0; m_cmp = '1; m_pre = 0; m_irq = 0;
      m_rv = 0; m_re = 0; m_rd = '0; m_rst = 1;
      m_q.delete();
    end else begin
      acc = v && rdy;
      m_rst = 0;
      m_rv = acc;
      m_re = acc && (k < 0);
      m_rd = '0;
      if (acc && !s)
        case (k)
          0: m_rd = m_time[31:0];
          1: m_rd = m_time[63:32];
          2: m_rd = m_cmp[31:0];
          3: m_rd = m_cmp[63:32];
          4: m_rd = 32'(m_q.size());
          default: m_rd = '0;
        endcase
      m_irq = (m_time >= m_cmp);
      if (m_q.size() != 0 && sr) void'(m_q.pop_front());
      if (acc && s && k == 0)      m_time = {m_time[63:32], d};
      else if (acc && s && k == 1) m_time = {d, m_time[31:0]};
      else if (m_pre == PRE - 1)   m_time = m_time + 64'd1;
      m_pre = (m_pre + 1) % PRE;
      if (acc && s && k == 2) m_cmp = {m_cmp[63:32], d};
      if (acc && s && k == 3) m_cmp = {d, m_cmp[31:0]};
      if (acc && s && k == 4) m_q.push_back(d[7:0]);
    end
    #1;
    chk("rspValid", bus.rspValid, m_rv);
    chk("rspError", bus.rspError, m_re);
    chk("rspData", bus.rspData, m_rd);
    chk("serialValid", bus.serialValid, m_q.size() != 0);
    chk("timerIrq", bus.timerIrq, m_irq);
    if (m_q.size() != 0) chk("serialData", bus.serialData, m_q[0]);
    else if (m_rst)      chk("serialData_rst", bus.serialData, 0);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit sr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 22'h0, 32'h0, sr);
  endtask

  task automatic ld(input logic [19:0] a, input bit sr);
    step(0, 1, 0, {2'b01, a}, 32'h0, sr);
  endtask

  task automatic st(input logic [19:0] a, input logic [31:0] d, input bit sr);
    step(0, 1, 1, {2'b01, a}, d, sr);
  endtask

  initial begin
    int tries;
    logic [21:0] ra;
    rst = 1'b1; bus.reqValid = 0; bus.reqIsStore = 0; bus.reqAddr = '0;
    bus.reqWriteData = '0; bus.serialReady = 0;
    m_time = '0; m_cmp = '1; m_pre = 0; m_irq = 0; m_rv = 0; m_re = 0; m_rd = '0; m_rst = 1;
    @(negedge clk);
    step(1, 0, 0, 22'h0, 32'h0, 0);
    step(1, 0, 0, 22'h0, 32'h0, 0);

    // Timer counts one per cycle from reset release
    idle(10, 1);
    ld(20'h0, 1);
    chk("tcount", bus.rspData, 10);

    // Carry from low into high word
    st(20'h4, 32'h0, 1); st(20'h0, 32'hFFFF_FFFE, 1); idle(2, 1);
    ld(20'h4, 1);
    chk("carry_hi", bus.rspData, 1);
    st(20'h4, 32'h0, 1); st(20'h0, 32'hFFFF_FFFE, 1); idle(2, 1);
    ld(20'h0, 1);
    chk("carry_lo", bus.rspData, 0);

    // Compare interrupt rises once mtime reaches 50, clears when cmp moves away
    st(20'h4, 32'h0, 1); st(20'h0, 32'd20, 1);
    st(20'hC, 32'h0, 1); st(20'h8, 32'd50, 1);
    chk("irq_low", bus.timerIrq, 0);
    idle(40, 1);
    chk("irq_high", bus.timerIrq, 1);
    st(20'h8, 32'hFFFF_FFFF, 1); idle(2, 1);
    chk("irq_clear", bus.timerIrq, 0);

    // Serial backpressure
    for (int i = 0; i < 4; i++) st(20'h2000, 32'h41 + i, 0);
    st(20'h2000, 32'h45, 0);
    chk("bp_ready", obs_rdy, 0);
    ld(20'h2000, 0);
    chk("bp_count", bus.rspData, 4);
    popped.delete();
    tries = 0;
    do begin
      st(20'h2000, 32'h45, 1);
      tries++;
    end while (!obs_rdy && tries < 10);
    chk("bp_retry", obs_rdy, 1);
    idle(6, 1);
    chk("bp_npop", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) chk("bp_order", popped[i], 8'h41 + i);

    // Steady push/pop at occupancy 2
    st(20'h2000, 32'h10, 0); st(20'h2000, 32'h11, 0);
    popped.delete();
    for (int i = 0; i < 10; i++) st(20'h2000, 32'h12 + i, 1);
    ld(20'h2000, 0);
    chk("pp_count", bus.rspData, 2);
    for (int i = 0; i < popped.size(); i++) chk("pp_order", popped[i], 8'h10 + i);
    idle(4, 1);

    // Decode errors
    ld(20'h10, 1);
    chk("err_raw", bus.rspError, 1);
    chk("err_data", bus.rspData, 0);
    step(0, 1, 0, 22'h0, 32'h0, 1);
    chk("err_noio", bus.rspError, 1);

    // Reset with bytes queued, and a request in the reset cycle
    for (int i = 0; i < 3; i++) st(20'h2000, 32'h60 + i, 0);
    step(1, 1, 1, {2'b01, 20'h2000}, 32'h77, 0);
    chk("rst_sv", bus.serialValid, 0);
    chk("rst_rv", bus.rspValid, 0);
    ld(20'h0, 1);
    chk("rst_mtime", bus.rspData, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: ra = 22'h0;
        1: ra = 22'h4;
        2: ra = 22'h8;
        3: ra = 22'hC;
        4, 5: ra = 22'h2000;
        6: ra = 22'h10;
        default: ra = 22'($urandom);
      endcase
      ra[20] = ($urandom_range(0, 9) != 0);
      ra[21] = 1'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, 1'($urandom), ra,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_timer_serial_unit.md
# mmio_timer_serial_unit

Memory-mapped IO target sitting directly downstream of the logical-to-physical address translation in the load/store path. It consumes requests whose physical address has `isIO` set and services the timer registers (physical 0x0_0000–0x0_000F) and the serial output port (physical 0x0_2000). It keeps a 64-bit free-running timer with a compare interrupt, and buffers serial bytes in a small FIFO drained by a ready/valid sink.

## Interface
Parameters:
- `SERIAL_FIFO_DEPTH`, default 4: number of serial byte entries. Must be a power of 2 and ≥ 2.
- `TIMER_PRESCALE`, default 1: clock cycles per `mtime` increment. Must be ≥ 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `reqValid` in 1: IO request present.
- `reqReady` out 1: request can be accepted this cycle.
- `reqIsStore` in 1: 1 = store, 0 = load.
- `reqAddr` in 22: physical address. Bit 21 is `isUncachable`, bit 20 is `isIO`, bits [19:0] are the raw address.
- `reqWriteData` in 32: store data. Accesses are full-word only.
- `rspValid` out 1: response pulse.
- `rspData` out 32: load data. It is 0 for stores and for errors.
- `rspError` out 1: the accepted request decoded to no register.
- `serialValid` out 1: FIFO head byte is valid.
- `serialData` out 8: FIFO head byte.
- `serialReady` in 1: the sink takes the head byte.
- `timerIrq` out 1: timer interrupt level.

## Operation
- **Accept:** a request is accepted when `reqValid && reqReady`.
- **`reqReady`:** combinational. It is 0 only when `reqValid`, the request is a store, it decodes to SERIAL, and the FIFO is full. It is 1 in every other case, including during reset.
- **Address decode:** requires `isIO` = 1. Raw address values:
  - 0x00 → MTIME_LO
  - 0x04 → MTIME_HI
  - 0x08 → CMP_LO
  - 0x0C → CMP_HI
  - 0x2000 → SERIAL
- **Decode errors:** any other raw address, or `isIO` = 0, is an error. The error still gets a response with `rspError` = 1 and `rspData` = 0, and it changes no state.
- **Loads:**
  - Timer registers return the register value held in the cycle of acceptance, i.e. before any update on that edge.
  - SERIAL returns the FIFO occupancy count, zero-extended to 32 bits.
- **Stores:**
  - MTIME_LO/HI replace that half of `mtime`. The other half holds, and there is no increment in that cycle.
  - CMP_LO/HI replace that half of `mtimecmp`.
  - SERIAL pushes `reqWriteData[7:0]`.
  - Stores to error addresses have no effect.
- **Timer:**
  - A prescale counter counts 0..`TIMER_PRESCALE`-1 and wraps.
  - `mtime` increments by 1 in a cycle where the prescale counter equals `TIMER_PRESCALE`-1 and no MTIME store is accepted.
  - The increment is a full 64-bit add. The low word carries into the high word, and 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - The prescale counter runs regardless of stores.
- **Interrupt:** `timerIrq` is a register loaded each cycle with (`mtime` >= `mtimecmp`), unsigned 64-bit, using current register values.
- **FIFO:**
  - Circular buffer with read/write pointers and a count of width clog2(`SERIAL_FIFO_DEPTH`)+1.
  - A pop occurs when `serialValid && serialReady`.
  - A push and a pop in the same cycle keep the count unchanged.
  - There is no fall-through: a byte pushed into an empty FIFO appears on `serialValid` the next cycle.
  - When full, pushes are blocked via `reqReady` even if a pop occurs in the same cycle.

## Timing
- **Response latency:** `rspValid`, `rspData` and `rspError` are registered and asserted exactly 1 cycle after acceptance, for one cycle. Back-to-back requests give back-to-back responses.
- **Store visibility:** a store's effect is visible to a load accepted in the next cycle.
- **Interrupt latency:** a CMP or MTIME store at edge n changes `timerIrq` at edge n+1, so it is visible 2 cycles after acceptance.
- **`serialValid`:** equals (count ≠ 0). `serialData` is the head entry, driven directly from registers.
- **Reset values** (synchronous, takes effect at the edge):
  - `mtime` = 0, `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, prescale counter = 0, FIFO empty, `timerIrq` = 0.
  - `rspValid` = 0, `rspData` = 0, `rspError` = 0, `serialValid` = 0, `serialData` = 0.
- **Reset mid-operation:** a request accepted in the reset cycle gets no response, and all pending FIFO bytes are discarded.

## Test plan
- **Timer count:** reset, `TIMER_PRESCALE`=1, idle 10 cycles, load MTIME_LO. Required: `rspData` = the cycle count since reset release (±0 exactly per the model), `rspError` = 0.
- **Carry:** store MTIME_LO = 0xFFFF_FFFE and MTIME_HI = 0. After 2 increments, MTIME_HI reads 1 and MTIME_LO reads 0.
- **Interrupt:** store CMP_HI = 0, then CMP_LO = 50 with `mtime` about 20. Required: `timerIrq` = 0 until `mtime` reaches 50, then 1 from the following cycle. Storing CMP_LO = 0xFFFF_FFFF then clears it.
- **Serial backpressure:** hold `serialReady` = 0 and store 0x41..0x45 to SERIAL. Required: the 5th store sees `reqReady` = 0 with depth 4, and a SERIAL load returns 4. Raise `serialReady`: bytes drain as 0x41, 0x42, 0x43, 0x44, then the 5th store is accepted and 0x45 follows.
- **Simultaneous push/pop:** keep the FIFO at 2 entries with `serialReady` = 1 while storing every cycle. Required: count stays 2 and output order is preserved.
- **Errors and reset:** a load at raw 0x10 gives `rspError` = 1 and `rspData` = 0. A load with `isIO` = 0 gives `rspError` = 1. Asserting `rst` with 3 bytes queued gives `serialValid` = 0 the next cycle and MTIME_LO reads from 0.
